l2_cache_write: RTL
===================

L2_CACHE_WRITE -- requirements
Module: l2_cache_write

Interface
REQ-001 SHALL have port clk, input, 1, pipeline clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset; clock clk.
REQ-003 SHALL have port l2r_request, input, l2req_packet_t, request from read stage (valid, packet_type, core, id, address, data, store_mask).
REQ-004 SHALL have port l2r_data, input, CACHE_LINE_BITS, line read from data SRAM.
REQ-005 SHALL have ports l2r_cache_hit, l2r_is_l2_fill, l2r_store_sync_success, input, 1 each; status from read stage.
REQ-006 SHALL have port l2r_hit_cache_idx, input, clog2(L2_WAYS*L2_SETS); SRAM index of hit or fill way.
REQ-007 SHALL have port l2r_data_from_memory, input, CACHE_LINE_BITS, fill data from bus interface.
REQ-008 SHALL have ports l2u_write_en (1), l2u_write_addr (clog2(L2_WAYS*L2_SETS)), l2u_write_data (CACHE_LINE_BITS), output; data SRAM write port.
REQ-009 SHALL have ports l2_response_valid (1), l2_response (l2rsp_packet_t), output; response to cores.

Function
REQ-010 Original line SHALL be l2r_data_from_memory when l2r_is_l2_fill, else l2r_data.
REQ-011 Merged line SHALL take byte i from l2r_request.data where store_mask[i]=1, else from original line, for i = 0..CACHE_LINE_BYTES-1.
REQ-012 Merge SHALL apply only for STORE, or STORE_SYNC with l2r_store_sync_success=1; otherwise merged line = original line.
REQ-013 l2u_write_en SHALL be combinational: request.valid && (l2r_is_l2_fill || (l2r_cache_hit && (STORE || (STORE_SYNC && sync_success)))).
REQ-014 l2u_write_addr SHALL equal l2r_hit_cache_idx; l2u_write_data SHALL equal merged line.
REQ-015 Failed STORE_SYNC SHALL NOT write SRAM.
REQ-016 FLUSH SHALL NOT write SRAM.
REQ-017 Response SHALL be registered; latency 1 cycle after the request is presented.
REQ-018 l2_response_valid SHALL assert for request.valid && (l2r_cache_hit || l2r_is_l2_fill || FLUSH); a non-fill miss SHALL produce no response (request is restarted by bus interface).
REQ-019 Response type mapping: LOAD/LOAD_SYNC -> LOAD_ACK; STORE/STORE_SYNC -> STORE_ACK; FLUSH -> FLUSH_ACK.
REQ-020 Response status SHALL be sync_success for STORE_SYNC, 1 for all other types.
REQ-021 Response core, id and address SHALL copy the request; data SHALL be merged line.
REQ-022 Fill + store SHALL write merged fill data in a single cycle; no separate hit pass.
REQ-023 Back-to-back writes to the same index SHALL rely on the SRAM NEW_DATA read-during-write behaviour; no local bypass.
REQ-024 Hit and fill both asserted SHALL be treated as illegal; assertion fires in simulation.

Reset
REQ-025 On reset: l2_response_valid=0, l2_response=0; l2u_write_en=0 regardless of inputs while reset is high.
REQ-026 Reset mid-transaction SHALL drop any pending response; first response after deassertion reflects only post-reset requests.

Structure
REQ-027 l2rsp_packet_t, response type enum, CACHE_LINE_BYTES SHALL live in the shared defines package.
REQ-028 Byte merge SHALL be a generate loop in this module; no sub-module is needed.

Verification
REQ-029 Store hit, mask 0x000...000F, data bytes 0xAA, line all 0x00 -> write_en=1, low 4 bytes 0xAA, rest 0x00; STORE_ACK status 1 next cycle.
REQ-030 Load miss, no fill -> write_en=0, no response.
REQ-031 Fill with memory line 0x55 repeated, store mask byte 0 = 0x11 -> write line byte0 0x11, rest 0x55; addr = hit_cache_idx.
REQ-032 STORE_SYNC hit, sync_success=0 -> write_en=0; STORE_ACK status 0.
REQ-033 FLUSH miss -> write_en=0; FLUSH_ACK status 1 next cycle.
REQ-034 Reset asserted the cycle after a load hit -> response_valid never observed high.

Source files
------------

// File: rtl/l2_cache_write_pkg.sv
// Shared L2 cache types: request/response packets, line geometry and
// the request-to-response type mapping used by the write stage.
package l2_cache_write_pkg;

    localparam int CACHE_LINE_BYTES = 64;
    localparam int CACHE_LINE_BITS  = CACHE_LINE_BYTES * 8;
    localparam int L2_WAYS          = 8;
    localparam int L2_SETS          = 64;
    localparam int L2_IDX_W         = $clog2(L2_WAYS * L2_SETS);
    localparam int CORE_W           = 4;
    localparam int ID_W             = 2;
    localparam int ADDR_W           = 26;

    typedef enum logic [2:0] {
        L2REQ_LOAD       = 3'd0,
        L2REQ_STORE      = 3'd1,
        L2REQ_FLUSH      = 3'd2,
        L2REQ_LOAD_SYNC  = 3'd3,
        L2REQ_STORE_SYNC = 3'd4
    } l2req_type_t;

    typedef enum logic [1:0] {
        L2RSP_LOAD_ACK  = 2'd0,
        L2RSP_STORE_ACK = 2'd1,
        L2RSP_FLUSH_ACK = 2'd2
    } l2rsp_type_t;

    typedef struct packed {
        logic                        valid;
        l2req_type_t                 packet_type;
        logic [CORE_W-1:0]           core;
        logic [ID_W-1:0]             id;
        logic [ADDR_W-1:0]           address;
        logic [CACHE_LINE_BITS-1:0]  data;
        logic [CACHE_LINE_BYTES-1:0] store_mask;
    } l2req_packet_t;

    typedef struct packed {
        logic                       status;
        l2rsp_type_t                packet_type;
        logic [CORE_W-1:0]          core;
        logic [ID_W-1:0]            id;
        logic [ADDR_W-1:0]          address;
        logic [CACHE_LINE_BITS-1:0] data;
    } l2rsp_packet_t;

    function automatic l2rsp_type_t rsp_type(input l2req_type_t t);
        l2rsp_type_t r;
        r = L2RSP_LOAD_ACK;
        case (t)
            L2REQ_STORE, L2REQ_STORE_SYNC: r = L2RSP_STORE_ACK;
            L2REQ_FLUSH:                   r = L2RSP_FLUSH_ACK;
            default:                       r = L2RSP_LOAD_ACK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l2_cache_write.sv
// L2 write stage: merges store bytes into the hit/fill line, drives the
// data SRAM write port and registers the response to the cores.
module l2_cache_write
    import l2_cache_write_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  l2req_packet_t              l2r_request,
    input  logic [CACHE_LINE_BITS-1:0] l2r_data,
    input  logic                       l2r_cache_hit,
    input  logic                       l2r_is_l2_fill,
    input  logic                       l2r_store_sync_success,
    input  logic [L2_IDX_W-1:0]        l2r_hit_cache_idx,
    input  logic [CACHE_LINE_BITS-1:0] l2r_data_from_memory,
    output logic                       l2u_write_en,
    output logic [L2_IDX_W-1:0]        l2u_write_addr,
    output logic [CACHE_LINE_BITS-1:0] l2u_write_data,
    output logic                       l2_response_valid,
    output l2rsp_packet_t              l2_response
);

    logic [CACHE_LINE_BITS-1:0] orig_line;
    logic [CACHE_LINE_BITS-1:0] merged_line;
    logic                       is_store;
    logic                       is_store_sync;
    logic                       is_flush;
    logic                       do_merge;
    logic                       rsp_valid_d;
    logic                       rsp_valid_q;
    l2rsp_packet_t              rsp_d;
    l2rsp_packet_t              rsp_q;

    assign orig_line = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data;

    assign is_store      = l2r_request.packet_type == L2REQ_STORE;
    assign is_store_sync = l2r_request.packet_type == L2REQ_STORE_SYNC;
    assign is_flush      = l2r_request.packet_type == L2REQ_FLUSH;
    assign do_merge      = is_store
                         || (is_store_sync && l2r_store_sync_success);

    for (genvar i = 0; i < CACHE_LINE_BYTES; i++) begin : g_merge
        assign merged_line[i*8 +: 8] =
            (do_merge && l2r_request.store_mask[i])
                ? l2r_request.data[i*8 +: 8]
                : orig_line[i*8 +: 8];
    end

    // A fill writes even without a store so the refilled line lands in SRAM.
    assign l2u_write_en = !reset && l2r_request.valid
                        && (l2r_is_l2_fill || (l2r_cache_hit && do_merge));
    assign l2u_write_addr = l2r_hit_cache_idx;
    assign l2u_write_data = merged_line;

    // Non-fill misses get no response; the bus interface restarts them.
    assign rsp_valid_d = l2r_request.valid
                       && (l2r_cache_hit || l2r_is_l2_fill || is_flush);

    always_comb begin
        rsp_d             = '0;
        rsp_d.status      = is_store_sync ? l2r_store_sync_success : 1'b1;
        rsp_d.packet_type = rsp_type(l2r_request.packet_type);
        rsp_d.core        = l2r_request.core;
        rsp_d.id          = l2r_request.id;
        rsp_d.address     = l2r_request.address;
        rsp_d.data        = merged_line;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign l2_response_valid = rsp_valid_q;
    assign l2_response       = rsp_q;

    a_hit_fill_exclusive: assert property (
        @(posedge clk) disable iff (reset)
        l2r_request.valid |-> !(l2r_cache_hit && l2r_is_l2_fill)
    );

endmodule
